kdf_param_loader: RTL and testbench
===================================

KDF_PARAM_LOADER -- requirements
Module: kdf_param_loader

Interface
REQ-001 SHALL have parameter SALT_WIDTH, default 64, salt width in bits (multiple of 8).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, iteration-count width in bits (multiple of 8).
REQ-003 SHALL have parameter PSW_WIDTH, default 32, password width in bits (multiple of 8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  8  parameter byte stream.
REQ-007 SHALL have port din_valid  input  1  din carries a byte.
REQ-008 SHALL have port din_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port salt  output  SALT_WIDTH  salt to the KDF core.
REQ-010 SHALL have port count  output  COUNT_WIDTH  iteration count to the KDF core.
REQ-011 SHALL have port user_password  output  PSW_WIDTH  password to the KDF core.
REQ-012 SHALL have port kdf_rst  output  1  reset/hold for the KDF core; low = run.
REQ-013 SHALL have port kdf_end  input  1  KDF core end_signal.
REQ-014 SHALL have port kdf_key  input  128  KDF core key_derivated.
REQ-015 SHALL have port key_out  output  128  captured derived key.
REQ-016 SHALL have port key_valid  output  1  key_out valid; held until key_ack.
REQ-017 SHALL have port key_ack  input  1  consumer took key_out.
REQ-018 SHALL have port key_err  output  1  captured key invalid (count was zero); qualified by key_valid.

Function
REQ-019 SHALL implement FSM states LOAD, RUN, DONE; reset state LOAD.
REQ-020 LOAD: din_ready=1, kdf_rst=1; byte accepted on din_valid&din_ready.
REQ-021 Byte order SHALL be password, salt, count, each MSB-first, i.e. the stream shifted left into a N_BYTES=(PSW_WIDTH+SALT_WIDTH+COUNT_WIDTH)/8 register forms {user_password,salt,count}.
REQ-022 Byte index SHALL count 0..N_BYTES-1; on acceptance of byte N_BYTES-1, next state RUN, index back to 0.
REQ-023 salt/count/user_password SHALL be driven directly from the shift register and SHALL be stable throughout RUN.
REQ-024 RUN: din_ready=0, kdf_rst=0 from the first cycle after the last byte edge.
REQ-025 RUN with count!=0: kdf_end sampled high SHALL capture kdf_key into key_out, key_err=0, next state DONE; kdf_end ignored in first RUN cycle.
REQ-026 RUN with count==0: SHALL not wait for kdf_end; next cycle key_out=0, key_err=1, state DONE.
REQ-027 DONE: kdf_rst=1, din_ready=0, key_valid=1; key_out/key_err held stable.
REQ-028 DONE with key_ack=1: next state LOAD, key_valid=0, key_out=0, key_err=0, shift register cleared.
REQ-029 key_ack outside DONE SHALL be ignored; kdf_end in LOAD/DONE SHALL be ignored.
REQ-030 din_valid while din_ready=0 SHALL be ignored (byte not consumed).
REQ-031 Latency: key_valid SHALL rise exactly one cycle after the cycle in which kdf_end is sampled high in RUN.

Reset
REQ-032 rst=1 SHALL, at the next edge, force LOAD, byte index 0, shift register 0, key_out 0, key_valid 0, key_err 0, kdf_rst 1, din_ready 1, regardless of state (including mid-load and mid-RUN).
REQ-033 rst SHALL override simultaneous din_valid, kdf_end, key_ack.

Structure
REQ-034 Package kdf_loader_pkg SHALL hold the state enum and N_BYTES/index-width derivation functions.
REQ-035 Byte index SHALL use the codebase counter sub-module; key_out SHALL use the codebase register sub-module (cl=rst or ack clear, w=capture).

Verification
REQ-036 Stream 16 bytes 01..10 with valid high continuously -> user_password=32'h01020304, salt=64'h05060708090A0B0C, count=32'h0D0E0F10, kdf_rst falls the cycle after byte 16.
REQ-037 Stream with valid gaps (toggling every other cycle) -> same register contents as REQ-036; din_ready stays 1 throughout LOAD.
REQ-038 count=3 with KDF model asserting kdf_end after 3 hashes, kdf_key=128'hA5..A5 -> key_valid next cycle, key_out=128'hA5..A5, key_err=0; hold 10 cycles without ack -> unchanged.
REQ-039 count=0 -> one cycle in RUN, then key_valid=1, key_err=1, key_out=0.
REQ-040 key_ack in DONE -> next cycle key_valid=0, key_out=0, din_ready=1; new 16-byte load succeeds.
REQ-041 rst asserted after byte 7 and again mid-RUN -> LOAD, outputs at reset values, kdf_rst=1; subsequent full load yields correct parameters.

Source files
------------

// File: rtl/kdf_loader_pkg.sv
// Shared definitions for the KDF parameter loader: controller states and
// helpers that size the byte stream and its index counter.
package kdf_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bytes in one parameter record (password + salt + count).
    function automatic int nBytes(input int pswWidth, input int saltWidth, input int countWidth);
        return (pswWidth + saltWidth + countWidth) / 8;
    endfunction

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kdf_param_loader_counter.sv
// Wrapping up-counter: counts 0..MAX_VALUE on each enabled cycle, then
// returns to zero. A synchronous clear takes priority over counting.
module kdf_param_loader_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 15
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MAX_VALUE);

    // Advance on enable, wrapping after the terminal value.
    always_ff @(posedge clk) begin
        if (cl) begin
            q <= '0;
        end else if (en) begin
            if (q == W_MAX) begin
                q <= '0;
            end else begin
                q <= q + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/kdf_param_loader_register.sv
// Loadable register with synchronous clear; clear wins over write.
module kdf_param_loader_register #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             w,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold the value unless cleared or written.
    always_ff @(posedge clk) begin
        if (cl) begin
            q <= '0;
        end else if (w) begin
            q <= d;
        end
    end

endmodule

// File: rtl/kdf_param_loader.sv
// Collects password/salt/count from a byte stream, releases the KDF core
// while the parameters are held, captures the derived key and presents it
// until the consumer acknowledges it.
module kdf_param_loader
    import kdf_loader_pkg::*;
#(
    parameter int SALT_WIDTH  = 64,
    parameter int COUNT_WIDTH = 32,
    parameter int PSW_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [SALT_WIDTH-1:0]  salt,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [PSW_WIDTH-1:0]   user_password,
    output logic                   kdf_rst,
    input  logic                   kdf_end,
    input  logic [127:0]           kdf_key,
    output logic [127:0]           key_out,
    output logic                   key_valid,
    input  logic                   key_ack,
    output logic                   key_err
);

    localparam int N_BYTES = nBytes(PSW_WIDTH, SALT_WIDTH, COUNT_WIDTH);
    localparam int IDX_W   = idxWidth(N_BYTES);
    localparam int TOTAL_W = N_BYTES * 8;

    state_t               r_state;
    logic [TOTAL_W-1:0]   r_shift;
    logic                 r_runFirst;
    logic                 r_keyErr;

    logic [IDX_W-1:0]     w_index;
    logic                 w_accept;
    logic                 w_lastByte;
    logic                 w_countZero;
    logic                 w_capture;
    logic                 w_zeroDone;
    logic                 w_ack;
    logic                 w_keyClear;
    logic                 w_keyWrite;
    logic [127:0]         w_keyData;

    assign w_accept    = din_valid && (r_state == ST_LOAD);
    assign w_lastByte  = w_accept && (w_index == IDX_W'(N_BYTES - 1));
    assign w_countZero = (count == '0);
    assign w_capture   = (r_state == ST_RUN) && !r_runFirst && !w_countZero && kdf_end;
    assign w_zeroDone  = (r_state == ST_RUN) && w_countZero;
    assign w_ack       = (r_state == ST_DONE) && key_ack;
    assign w_keyClear  = rst || w_ack;
    assign w_keyWrite  = w_capture || w_zeroDone;
    assign w_keyData   = w_capture ? kdf_key : '0;

    kdf_param_loader_counter #(
        .WIDTH     (IDX_W),
        .MAX_VALUE (N_BYTES - 1)
    ) u_byteIndex (
        .clk (clk),
        .cl  (rst),
        .en  (w_accept),
        .q   (w_index)
    );

    kdf_param_loader_register #(
        .WIDTH (128)
    ) u_keyReg (
        .clk (clk),
        .cl  (w_keyClear),
        .w   (w_keyWrite),
        .d   (w_keyData),
        .q   (key_out)
    );

    // Controller: shift bytes in, wait for the core, hold the key until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_shift    <= '0;
            r_runFirst <= 1'b0;
            r_keyErr   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_shift <= {r_shift[TOTAL_W-9:0], din};
                    end
                    if (w_lastByte) begin
                        r_state    <= ST_RUN;
                        r_runFirst <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_runFirst <= 1'b0;
                    if (w_zeroDone) begin
                        r_keyErr <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_capture) begin
                        r_keyErr <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (key_ack) begin
                        r_state  <= ST_LOAD;
                        r_shift  <= '0;
                        r_keyErr <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign user_password = r_shift[TOTAL_W-1 -: PSW_WIDTH];
    assign salt          = r_shift[COUNT_WIDTH+SALT_WIDTH-1 -: SALT_WIDTH];
    assign count         = r_shift[COUNT_WIDTH-1:0];
    assign din_ready     = (r_state == ST_LOAD);
    assign kdf_rst       = (r_state != ST_RUN);
    assign key_valid     = (r_state == ST_DONE);
    assign key_err       = r_keyErr;

endmodule

// File: tb/tb_kdf_param_loader.sv
// Scoreboard bench for kdf_param_loader: stimulus pushes the expected
// parameter record and key result, a negedge monitor pops and compares
// whenever the DUT enters RUN or raises key_valid.
module tb_kdf_param_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_ready;
    logic [63:0]  salt;
    logic [31:0]  count;
    logic [31:0]  user_password;
    logic         kdf_rst;
    logic         kdf_end;
    logic [127:0] kdf_key;
    logic [127:0] key_out;
    logic         key_valid;
    logic         key_ack;
    logic         key_err;

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [127:0] paramQ[$];
    logic [128:0] keyQ[$];

    kdf_param_loader #(
        .SALT_WIDTH  (64),
        .COUNT_WIDTH (32),
        .PSW_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .salt          (salt),
        .count         (count),
        .user_password (user_password),
        .kdf_rst       (kdf_rst),
        .kdf_end       (kdf_end),
        .kdf_key       (kdf_key),
        .key_out       (key_out),
        .key_valid     (key_valid),
        .key_ack       (key_ack),
        .key_err       (key_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream the first nBytes of a record, MSB first, optionally with idle gaps.
    task automatic applyStimulus(input logic [127:0] data, input int nBytes, input bit gaps);
        if (nBytes == 16) paramQ.push_back(data);
        for (int i = 0; i < nBytes; i++) begin
            if (gaps && i > 0) begin
                din_valid = 1'b0;
                din       = 8'($urandom);
                tick();
                checkOutput("dinReadyGap", 256'(din_ready), 256'(1));
            end
            din_valid = 1'b1;
            din       = data[127-8*i -: 8];
            if (i == nBytes - 1) checkOutput("kdfRstBeforeLast", 256'(kdf_rst), 256'(1));
            tick();
        end
        din_valid = 1'b0;
    endtask

    // Reference KDF core: ignores its run state for one cycle, computes
    // count hashes (capped for simulation time), then signals end with the key.
    task automatic runKdf(input logic [31:0] cnt, input logic [127:0] key, input int holdCycles);
        int hashes;
        hashes = (cnt > 32'd20) ? 20 : int'(cnt);
        checkOutput("kdfRstRun", 256'(kdf_rst), 256'(0));
        checkOutput("dinReadyRun", 256'(din_ready), 256'(0));
        kdf_end   = 1'b1;
        kdf_key   = ~key;
        key_ack   = 1'b1;
        din_valid = 1'b1;
        din       = 8'($urandom);
        if (cnt == 32'd0) begin
            keyQ.push_back({128'h0, 1'b1});
            tick();
            kdf_end = 1'b0;
            key_ack = 1'b0;
            checkOutput("zeroCountDone", 256'(key_valid), 256'(1));
        end else begin
            keyQ.push_back({key, 1'b0});
            tick();
            kdf_end = 1'b0;
            key_ack = 1'b0;
            checkOutput("firstRunEndIgnored", 256'(key_valid), 256'(0));
            repeat (hashes - 1) tick();
            checkOutput("keyValidBeforeEnd", 256'(key_valid), 256'(0));
            kdf_end = 1'b1;
            kdf_key = key;
            tick();
            kdf_end = 1'b0;
            kdf_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            checkOutput("keyLatency", 256'(key_valid), 256'(1));
        end
        repeat (holdCycles) tick();
        din_valid = 1'b0;
        key_ack   = 1'b1;
        tick();
        key_ack = 1'b0;
        checkOutput("ackKeyValid", 256'(key_valid), 256'(0));
        checkOutput("ackKeyOut", 256'({key_out, key_err}), 256'(0));
        checkOutput("ackDinReady", 256'(din_ready), 256'(1));
        checkOutput("ackParams", 256'({user_password, salt, count}), 256'(0));
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "State"}, 256'({din_ready, kdf_rst, key_valid, key_err}), 256'(4'b1100));
        checkOutput({name, "Data"}, 256'({user_password, salt, count}), 256'(0));
        checkOutput({name, "Key"}, 256'(key_out), 256'(0));
    endtask

    // Monitor: compare parameters on RUN entry and key results while DONE.
    logic         prevKdfRst   = 1'b1;
    logic         prevKeyValid = 1'b0;
    logic [128:0] heldExp      = '0;
    always @(negedge clk) begin
        if (prevKdfRst && !kdf_rst) begin
            if (paramQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL paramQueue: RUN entered with no record expected");
            end else begin
                checkOutput("params", 256'({user_password, salt, count}), 256'(paramQ.pop_front()));
            end
        end
        if (key_valid && !prevKeyValid) begin
            if (keyQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL keyQueue: key_valid rose with no result expected, key_out=%0h", key_out);
            end else begin
                heldExp = keyQ.pop_front();
                checkOutput("keyResult", 256'({key_out, key_err}), 256'(heldExp));
            end
        end else if (key_valid) begin
            checkOutput("keyHold", 256'({key_out, key_err}), 256'(heldExp));
        end
        prevKdfRst   = kdf_rst;
        prevKeyValid = key_valid;
    end

    // Directed scenarios followed by randomized records.
    initial begin
        logic [127:0] seqData;
        logic [127:0] data;
        logic [127:0] key;
        int           sel;
        seqData   = 128'h0102030405060708090A0B0C0D0E0F10;
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        kdf_end   = 1'b0;
        kdf_key   = '0;
        key_ack   = 1'b0;
        repeat (3) tick();
        checkResetState("reset");
        rst = 1'b0;
        tick();

        applyStimulus(seqData, 16, 1'b0);
        checkOutput("seqPassword", 256'(user_password), 256'(32'h01020304));
        checkOutput("seqSalt", 256'(salt), 256'(64'h05060708090A0B0C));
        checkOutput("seqCount", 256'(count), 256'(32'h0D0E0F10));
        runKdf(32'h0D0E0F10, {4{32'h12345678}}, 2);

        applyStimulus(seqData, 16, 1'b1);
        runKdf(32'h0D0E0F10, {4{32'hCAFEF00D}}, 1);

        data = {32'hDEADBEEF, 64'h0011223344556677, 32'd3};
        applyStimulus(data, 16, 1'b0);
        runKdf(32'd3, {16{8'hA5}}, 10);

        data = {32'h11111111, 64'h2222222222222222, 32'd0};
        applyStimulus(data, 16, 1'b1);
        runKdf(32'd0, '0, 3);

        applyStimulus(seqData, 7, 1'b0);
        din_valid = 1'b1;
        kdf_end   = 1'b1;
        key_ack   = 1'b1;
        rst       = 1'b1;
        tick();
        checkResetState("midLoadReset");
        rst       = 1'b0;
        din_valid = 1'b0;
        kdf_end   = 1'b0;
        key_ack   = 1'b0;
        tick();

        applyStimulus(seqData, 16, 1'b0);
        tick();
        tick();
        kdf_end = 1'b1;
        kdf_key = {16{8'h5A}};
        key_ack = 1'b1;
        rst     = 1'b1;
        tick();
        checkResetState("midRunReset");
        rst     = 1'b0;
        kdf_end = 1'b0;
        key_ack = 1'b0;
        tick();
        checkResetState("afterRunReset");

        applyStimulus(seqData, 16, 1'b0);
        checkOutput("reloadPassword", 256'(user_password), 256'(32'h01020304));
        runKdf(32'h0D0E0F10, {4{32'h0BADC0DE}}, 0);

        for (int n = 0; n < 20; n++) begin
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            sel  = $urandom_range(0, 3);
            if (sel == 0) data[31:0] = 32'd0;
            else if (sel == 1) data[31:0] = 32'($urandom_range(1, 5));
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(data, 16, 1'($urandom_range(0, 1)));
            runKdf(data[31:0], key, $urandom_range(0, 4));
        end

        repeat (2) tick();
        checkOutput("paramQueueDrained", 256'(paramQ.size()), 256'(0));
        checkOutput("keyQueueDrained", 256'(keyQ.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
